// File: rtl/ysyx_mem_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU memory bus arbiter.
package ysyx_mem_arbiter_pkg;

  localparam int unsigned BYTE_LANES = 4;
  localparam int unsigned STRB_IN_W  = 8;
  localparam int unsigned SIZE_W     = 3;
  localparam int unsigned RESP_W     = 2;
  localparam int unsigned OFF_W      = 2;

  typedef enum logic [2:0] {
    ARB_IDLE = 3'd0,
    ARB_AR   = 3'd1,
    ARB_R    = 3'd2,
    ARB_AW_W = 3'd3,
    ARB_B    = 3'd4
  } arb_state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_e;

  localparam logic [SIZE_W-1:0] AXI_SIZE_BYTE = 3'd0;
  localparam logic [SIZE_W-1:0] AXI_SIZE_HALF = 3'd1;
  localparam logic [SIZE_W-1:0] AXI_SIZE_WORD = 3'd2;

  localparam logic [RESP_W-1:0] AXI_RESP_OKAY = 2'd0;

  // Byte strobe to AXI size; anything unexpected is treated as a full word.
  function automatic logic [SIZE_W-1:0] strb_to_size(input logic [STRB_IN_W-1:0] strb);
    logic [SIZE_W-1:0] size;
    case (strb)
      8'h01:   size = AXI_SIZE_BYTE;
      8'h03:   size = AXI_SIZE_HALF;
      default: size = AXI_SIZE_WORD;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/ysyx_mem_arbiter_wr_align.sv
// Converts an LSB-justified LSU strobe/data into AXI size and lane-aligned strobe/data.
module ysyx_mem_arbiter_wr_align
  import ysyx_mem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [STRB_IN_W-1:0]  i_strb,
  input  logic [OFF_W-1:0]      i_off,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic [SIZE_W-1:0]     o_size,
  output logic [BYTE_LANES-1:0] o_wstrb,
  output logic [DATA_W-1:0]     o_wdata
);

  // Shift strobe and data up to the byte lane selected by the low address bits.
  always_comb begin
    o_size  = strb_to_size(i_strb);
    o_wstrb = BYTE_LANES'(i_strb[BYTE_LANES-1:0] << i_off);
    o_wdata = i_wdata << {i_off, 3'b000};
  end

endmodule

// File: rtl/ysyx_mem_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite-style master port between IFU and LSU.
module ysyx_mem_arbiter
  import ysyx_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // instruction fetch
  input  logic [ADDR_W-1:0]     ifu_araddr,
  input  logic                  ifu_arvalid,
  output logic [DATA_W-1:0]     ifu_rdata_o,
  output logic                  ifu_rvalid_o,
  // load
  input  logic [ADDR_W-1:0]     lsu_araddr,
  input  logic                  lsu_arvalid,
  input  logic [STRB_IN_W-1:0]  lsu_rstrb,
  output logic [DATA_W-1:0]     lsu_rdata_o,
  output logic                  lsu_rvalid_o,
  // store
  input  logic [ADDR_W-1:0]     lsu_awaddr,
  input  logic                  lsu_awvalid,
  input  logic [DATA_W-1:0]     lsu_wdata,
  input  logic [STRB_IN_W-1:0]  lsu_wstrb,
  input  logic                  lsu_wvalid,
  output logic                  lsu_wready_o,
  output logic                  bus_err_o,
  // read address channel
  output logic [ADDR_W-1:0]     bus_araddr,
  output logic                  bus_arvalid,
  output logic [SIZE_W-1:0]     bus_arsize,
  input  logic                  bus_arready,
  // read data channel
  input  logic [DATA_W-1:0]     bus_rdata,
  input  logic [RESP_W-1:0]     bus_rresp,
  input  logic                  bus_rvalid,
  output logic                  bus_rready,
  // write address channel
  output logic [ADDR_W-1:0]     bus_awaddr,
  output logic                  bus_awvalid,
  output logic [SIZE_W-1:0]     bus_awsize,
  input  logic                  bus_awready,
  // write data channel
  output logic [DATA_W-1:0]     bus_wdata,
  output logic [BYTE_LANES-1:0] bus_wstrb,
  output logic                  bus_wvalid,
  input  logic                  bus_wready,
  // write response channel
  input  logic [RESP_W-1:0]     bus_bresp,
  input  logic                  bus_bvalid,
  output logic                  bus_bready
);

  arb_state_e              r_state;
  arb_owner_e              r_owner;
  arb_owner_e              r_last_grant;

  logic [ADDR_W-1:0]       r_araddr;
  logic [SIZE_W-1:0]       r_arsize;
  logic                    r_arvalid;
  logic                    r_rready;
  logic [ADDR_W-1:0]       r_awaddr;
  logic [SIZE_W-1:0]       r_awsize;
  logic                    r_awvalid;
  logic [DATA_W-1:0]       r_wdata;
  logic [BYTE_LANES-1:0]   r_wstrb;
  logic                    r_wvalid;
  logic                    r_aw_done;
  logic                    r_w_done;
  logic                    r_bready;

  logic [DATA_W-1:0]       r_ifu_rdata;
  logic                    r_ifu_rvalid;
  logic [DATA_W-1:0]       r_lsu_rdata;
  logic                    r_lsu_rvalid;
  logic                    r_lsu_wready;
  logic                    r_bus_err;

  logic                    w_store_req;
  logic                    w_grant_lsu_rd;
  logic                    w_grant_ifu;
  logic                    w_resp_busy;
  logic                    w_aw_hs;
  logic                    w_w_hs;
  logic [STRB_IN_W-1:0]    w_align_strb;
  logic [SIZE_W-1:0]       w_size;
  logic [BYTE_LANES-1:0]   w_wstrb;
  logic [DATA_W-1:0]       w_wdata;

  // Request decode; a pending store always wins, reads go round-robin.
  assign w_store_req    = lsu_awvalid & lsu_wvalid;
  assign w_grant_lsu_rd = lsu_arvalid & (~ifu_arvalid | (r_last_grant == OWN_IFU));
  assign w_grant_ifu    = ifu_arvalid & (~lsu_arvalid | (r_last_grant == OWN_LSU));
  // A requester may still hold valid in the cycle its response pulse is out.
  assign w_resp_busy    = r_ifu_rvalid | r_lsu_rvalid | r_lsu_wready;
  assign w_aw_hs        = r_awvalid & bus_awready;
  assign w_w_hs         = r_wvalid & bus_wready;
  // Loads and stores never share a grant, so one aligner serves both sizes.
  assign w_align_strb   = w_store_req ? lsu_wstrb : lsu_rstrb;

  ysyx_mem_arbiter_wr_align #(
    .DATA_W (DATA_W)
  ) u_wr_align (
    .i_strb  (w_align_strb),
    .i_off   (lsu_awaddr[OFF_W-1:0]),
    .i_wdata (lsu_wdata),
    .o_size  (w_size),
    .o_wstrb (w_wstrb),
    .o_wdata (w_wdata)
  );

  // Arbitration FSM with all downstream and response outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ARB_IDLE;
      r_owner      <= OWN_IFU;
      r_last_grant <= OWN_IFU;
      r_araddr     <= '0;
      r_arsize     <= '0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awaddr     <= '0;
      r_awsize     <= '0;
      r_awvalid    <= 1'b0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_wvalid     <= 1'b0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_bready     <= 1'b0;
      r_ifu_rdata  <= '0;
      r_ifu_rvalid <= 1'b0;
      r_lsu_rdata  <= '0;
      r_lsu_rvalid <= 1'b0;
      r_lsu_wready <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      r_ifu_rvalid <= 1'b0;
      r_lsu_rvalid <= 1'b0;
      r_lsu_wready <= 1'b0;
      r_bus_err    <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (!w_resp_busy) begin
            if (w_store_req) begin
              r_state      <= ARB_AW_W;
              r_owner      <= OWN_LSU;
              r_last_grant <= OWN_LSU;
              r_awaddr     <= lsu_awaddr;
              r_awsize     <= w_size;
              r_wdata      <= w_wdata;
              r_wstrb      <= w_wstrb;
              r_awvalid    <= 1'b1;
              r_wvalid     <= 1'b1;
              r_aw_done    <= 1'b0;
              r_w_done     <= 1'b0;
            end else if (w_grant_lsu_rd) begin
              r_state      <= ARB_AR;
              r_owner      <= OWN_LSU;
              r_last_grant <= OWN_LSU;
              r_araddr     <= lsu_araddr;
              r_arsize     <= w_size;
              r_arvalid    <= 1'b1;
            end else if (w_grant_ifu) begin
              r_state      <= ARB_AR;
              r_owner      <= OWN_IFU;
              r_last_grant <= OWN_IFU;
              r_araddr     <= ifu_araddr;
              r_arsize     <= AXI_SIZE_WORD;
              r_arvalid    <= 1'b1;
            end
          end
        end
        ARB_AR: begin
          if (bus_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ARB_R;
          end
        end
        ARB_R: begin
          if (bus_rvalid) begin
            r_rready  <= 1'b0;
            r_bus_err <= (bus_rresp != AXI_RESP_OKAY);
            if (r_owner == OWN_IFU) begin
              r_ifu_rvalid <= 1'b1;
              r_ifu_rdata  <= bus_rdata;
            end else begin
              r_lsu_rvalid <= 1'b1;
              r_lsu_rdata  <= bus_rdata;
            end
            r_state <= ARB_IDLE;
          end
        end
        ARB_AW_W: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
            r_bready <= 1'b1;
            r_state  <= ARB_B;
          end
        end
        ARB_B: begin
          if (bus_bvalid) begin
            r_bready     <= 1'b0;
            r_lsu_wready <= 1'b1;
            r_bus_err    <= (bus_bresp != AXI_RESP_OKAY);
            r_state      <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign ifu_rdata_o  = r_ifu_rdata;
  assign ifu_rvalid_o = r_ifu_rvalid;
  assign lsu_rdata_o  = r_lsu_rdata;
  assign lsu_rvalid_o = r_lsu_rvalid;
  assign lsu_wready_o = r_lsu_wready;
  assign bus_err_o    = r_bus_err;
  assign bus_araddr   = r_araddr;
  assign bus_arvalid  = r_arvalid;
  assign bus_arsize   = r_arsize;
  assign bus_rready   = r_rready;
  assign bus_awaddr   = r_awaddr;
  assign bus_awvalid  = r_awvalid;
  assign bus_awsize   = r_awsize;
  assign bus_wdata    = r_wdata;
  assign bus_wstrb    = r_wstrb;
  assign bus_wvalid   = r_wvalid;
  assign bus_bready   = r_bready;

endmodule

// File: tb/tb_ysyx_mem_arbiter.sv
// Scoreboard bench for ysyx_mem_arbiter with a small configurable AXI slave.
module tb_ysyx_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ifu_araddr;
  logic        ifu_arvalid;
  logic [31:0] ifu_rdata_o;
  logic        ifu_rvalid_o;
  logic [31:0] lsu_araddr;
  logic        lsu_arvalid;
  logic [7:0]  lsu_rstrb;
  logic [31:0] lsu_rdata_o;
  logic        lsu_rvalid_o;
  logic [31:0] lsu_awaddr;
  logic        lsu_awvalid;
  logic [31:0] lsu_wdata;
  logic [7:0]  lsu_wstrb;
  logic        lsu_wvalid;
  logic        lsu_wready_o;
  logic        bus_err_o;
  logic [31:0] bus_araddr;
  logic        bus_arvalid;
  logic [2:0]  bus_arsize;
  logic        bus_arready;
  logic [31:0] bus_rdata;
  logic [1:0]  bus_rresp;
  logic        bus_rvalid;
  logic        bus_rready;
  logic [31:0] bus_awaddr;
  logic        bus_awvalid;
  logic [2:0]  bus_awsize;
  logic        bus_awready;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_wvalid;
  logic        bus_wready;
  logic [1:0]  bus_bresp;
  logic        bus_bvalid;
  logic        bus_bready;

  localparam logic [31:0] RD_KEY = 32'hDEAD0000;

  typedef struct {
    logic [2:0]  hot;   // {store, load, fetch}
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic [34:0] exp_ar[$];   // {addr, size}
  logic [34:0] exp_aw[$];   // {addr, size}
  logic [35:0] exp_w[$];    // {strb, data}
  rsp_t        exp_rsp[$];

  int n_cmp = 0;
  int n_bad = 0;

  // slave knobs
  logic       slv_hold = 1'b0;
  logic [1:0] slv_rresp = 2'd0;
  logic [1:0] slv_bresp = 2'd0;
  int         aw_wait = 0;
  int         w_wait = 0;
  int         aw_cnt = 0;
  int         w_cnt = 0;

  ysyx_mem_arbiter u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ifu_araddr   (ifu_araddr),
    .ifu_arvalid  (ifu_arvalid),
    .ifu_rdata_o  (ifu_rdata_o),
    .ifu_rvalid_o (ifu_rvalid_o),
    .lsu_araddr   (lsu_araddr),
    .lsu_arvalid  (lsu_arvalid),
    .lsu_rstrb    (lsu_rstrb),
    .lsu_rdata_o  (lsu_rdata_o),
    .lsu_rvalid_o (lsu_rvalid_o),
    .lsu_awaddr   (lsu_awaddr),
    .lsu_awvalid  (lsu_awvalid),
    .lsu_wdata    (lsu_wdata),
    .lsu_wstrb    (lsu_wstrb),
    .lsu_wvalid   (lsu_wvalid),
    .lsu_wready_o (lsu_wready_o),
    .bus_err_o    (bus_err_o),
    .bus_araddr   (bus_araddr),
    .bus_arvalid  (bus_arvalid),
    .bus_arsize   (bus_arsize),
    .bus_arready  (bus_arready),
    .bus_rdata    (bus_rdata),
    .bus_rresp    (bus_rresp),
    .bus_rvalid   (bus_rvalid),
    .bus_rready   (bus_rready),
    .bus_awaddr   (bus_awaddr),
    .bus_awvalid  (bus_awvalid),
    .bus_awsize   (bus_awsize),
    .bus_awready  (bus_awready),
    .bus_wdata    (bus_wdata),
    .bus_wstrb    (bus_wstrb),
    .bus_wvalid   (bus_wvalid),
    .bus_wready   (bus_wready),
    .bus_bresp    (bus_bresp),
    .bus_bvalid   (bus_bvalid),
    .bus_bready   (bus_bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave: reacts just after each rising edge to the freshly registered DUT outputs.
  initial begin
    bus_arready = 1'b1;
    bus_rvalid  = 1'b0;
    bus_rdata   = '0;
    bus_rresp   = '0;
    bus_awready = 1'b0;
    bus_wready  = 1'b0;
    bus_bvalid  = 1'b0;
    bus_bresp   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus_rready && !slv_hold) begin
        bus_rvalid = 1'b1;
        bus_rdata  = bus_araddr ^ RD_KEY;
        bus_rresp  = slv_rresp;
      end else begin
        bus_rvalid = 1'b0;
      end
      if (bus_awvalid) begin
        if (aw_cnt >= aw_wait) bus_awready = 1'b1;
        else begin bus_awready = 1'b0; aw_cnt++; end
      end else begin
        bus_awready = 1'b0;
        aw_cnt = 0;
      end
      if (bus_wvalid) begin
        if (w_cnt >= w_wait) bus_wready = 1'b1;
        else begin bus_wready = 1'b0; w_cnt++; end
      end else begin
        bus_wready = 1'b0;
        w_cnt = 0;
      end
      bus_bvalid = bus_bready;
      bus_bresp  = slv_bresp;
    end
  end

  // Monitor: compares bus handshakes and response pulses against the queues.
  always @(negedge clk) begin
    logic [2:0]  hot;
    logic [31:0] dat;
    rsp_t        e;
    logic [34:0] ea;
    logic [35:0] ew;
    if (rst_n) begin
      if (bus_arvalid && bus_arready) begin
        if (exp_ar.size() == 0) chk("unexpected_ar", {29'b0, bus_araddr, bus_arsize}, 64'h0);
        else begin
          ea = exp_ar.pop_front();
          chk("ar_addr_size", {29'b0, bus_araddr, bus_arsize}, {29'b0, ea});
        end
      end
      if (bus_awvalid && bus_awready) begin
        if (exp_aw.size() == 0) chk("unexpected_aw", {29'b0, bus_awaddr, bus_awsize}, 64'h0);
        else begin
          ea = exp_aw.pop_front();
          chk("aw_addr_size", {29'b0, bus_awaddr, bus_awsize}, {29'b0, ea});
        end
      end
      if (bus_wvalid && bus_wready) begin
        if (exp_w.size() == 0) chk("unexpected_w", {28'b0, bus_wstrb, bus_wdata}, 64'h0);
        else begin
          ew = exp_w.pop_front();
          chk("w_strb_data", {28'b0, bus_wstrb, bus_wdata}, {28'b0, ew});
        end
      end
      if (bus_bready) chk("b_before_aw_w_done", {62'b0, bus_awvalid, bus_wvalid}, 64'h0);
      hot = {lsu_wready_o, lsu_rvalid_o, ifu_rvalid_o};
      dat = ifu_rvalid_o ? ifu_rdata_o : (lsu_rvalid_o ? lsu_rdata_o : 32'h0);
      if (hot != 3'b000) begin
        if (exp_rsp.size() == 0) chk("unexpected_rsp", {61'b0, hot}, 64'h0);
        else begin
          e = exp_rsp.pop_front();
          chk("rsp_owner_data_err", {28'b0, hot, dat, bus_err_o}, {28'b0, e.hot, e.data, e.err});
        end
      end else if (bus_err_o) begin
        chk("stray_err", 64'h1, 64'h0);
      end
    end
  end

  task automatic do_fetch(input logic [31:0] a, output int lat);
    bit seen = 0;
    ifu_araddr  = a;
    ifu_arvalid = 1'b1;
    lat = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (ifu_rvalid_o) seen = 1;
    end
    if (!seen) chk("fetch_timeout", 64'h0, 64'h1);
    ifu_arvalid = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [7:0] strb);
    bit seen = 0;
    lsu_araddr  = a;
    lsu_rstrb   = strb;
    lsu_arvalid = 1'b1;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (lsu_rvalid_o) seen = 1;
    end
    if (!seen) chk("load_timeout", 64'h0, 64'h1);
    lsu_arvalid = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [7:0] strb);
    bit seen = 0;
    lsu_awaddr  = a;
    lsu_wdata   = d;
    lsu_wstrb   = strb;
    lsu_awvalid = 1'b1;
    lsu_wvalid  = 1'b1;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (lsu_wready_o) seen = 1;
    end
    if (!seen) chk("store_timeout", 64'h0, 64'h1);
    lsu_awvalid = 1'b0;
    lsu_wvalid  = 1'b0;
  endtask

  function automatic rsp_t mk_rsp(input logic [2:0] hot, input logic [31:0] d, input logic err);
    rsp_t r;
    r.hot  = hot;
    r.data = d;
    r.err  = err;
    return r;
  endfunction

  // Push expectations for one store and run it.
  task automatic store_case(input logic [31:0] a, input logic [31:0] d, input logic [7:0] strb,
                            input logic [2:0] sz, input logic [3:0] es, input logic [31:0] ed,
                            input logic err);
    exp_aw.push_back({a, sz});
    exp_w.push_back({es, ed});
    exp_rsp.push_back(mk_rsp(3'b100, 32'h0, err));
    do_store(a, d, strb);
  endtask

  task automatic load_case(input logic [31:0] a, input logic [7:0] strb, input logic [2:0] sz,
                           input logic err);
    exp_ar.push_back({a, sz});
    exp_rsp.push_back(mk_rsp(3'b010, a ^ RD_KEY, err));
    do_load(a, strb);
  endtask

  initial begin
    int lat;
    int lat_a;
    int lat_b;
    bit seen;
    ifu_araddr = '0; ifu_arvalid = 1'b0;
    lsu_araddr = '0; lsu_arvalid = 1'b0; lsu_rstrb = '0;
    lsu_awaddr = '0; lsu_awvalid = 1'b0; lsu_wdata = '0; lsu_wstrb = '0; lsu_wvalid = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valids", {55'b0, bus_arvalid, bus_rready, bus_awvalid, bus_wvalid, bus_bready,
                         ifu_rvalid_o, lsu_rvalid_o, lsu_wready_o, bus_err_o}, 64'h0);
    chk("reset_addr", {bus_araddr, bus_awaddr}, 64'h0);
    chk("reset_data", {bus_wdata, 22'b0, bus_wstrb, bus_arsize, bus_awsize}, 64'h0);
    chk("reset_rdata", {ifu_rdata_o, lsu_rdata_o}, 64'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single fetch, zero-wait slave
    exp_ar.push_back({32'h80000004, 3'd2});
    exp_rsp.push_back(mk_rsp(3'b001, 32'h80000004 ^ RD_KEY, 1'b0));
    do_fetch(32'h80000004, lat);
    chk("fetch_latency", 64'(lat), 64'd3);

    // contending reads: LSU, IFU, LSU, IFU
    exp_ar.push_back({32'h20000000, 3'd2});
    exp_ar.push_back({32'h80000100, 3'd2});
    exp_ar.push_back({32'h20000004, 3'd2});
    exp_ar.push_back({32'h80000104, 3'd2});
    exp_rsp.push_back(mk_rsp(3'b010, 32'h20000000 ^ RD_KEY, 1'b0));
    exp_rsp.push_back(mk_rsp(3'b001, 32'h80000100 ^ RD_KEY, 1'b0));
    exp_rsp.push_back(mk_rsp(3'b010, 32'h20000004 ^ RD_KEY, 1'b0));
    exp_rsp.push_back(mk_rsp(3'b001, 32'h80000104 ^ RD_KEY, 1'b0));
    fork
      begin do_load(32'h20000000, 8'h0f); do_load(32'h20000004, 8'h0f); end
      begin do_fetch(32'h80000100, lat_a); do_fetch(32'h80000104, lat_b); end
    join

    // store alignment: byte and half at various offsets
    store_case(32'h30000003, 32'h000000A5, 8'h01, 3'd0, 4'h8, 32'hA5000000, 1'b0);
    store_case(32'h30000001, 32'h0000005A, 8'h01, 3'd0, 4'h2, 32'h00005A00, 1'b0);
    store_case(32'h30000002, 32'h00001234, 8'h03, 3'd1, 4'hC, 32'h12340000, 1'b0);
    store_case(32'h30000003, 32'h0000BEEF, 8'h03, 3'd1, 4'h8, 32'hEF000000, 1'b0);

    // awready two cycles ahead of wready
    aw_wait = 0;
    w_wait  = 2;
    store_case(32'h30000010, 32'hCAFEBABE, 8'h0f, 3'd2, 4'hF, 32'hCAFEBABE, 1'b0);
    w_wait  = 0;

    // load sizes, including an unexpected strobe
    load_case(32'h20000001, 8'h01, 3'd0, 1'b0);
    load_case(32'h20000008, 8'h07, 3'd2, 1'b0);

    // error responses
    slv_rresp = 2'd2;
    load_case(32'h20000006, 8'h03, 3'd1, 1'b1);
    slv_rresp = 2'd0;
    slv_bresp = 2'd3;
    store_case(32'h30000020, 32'h11223344, 8'h0f, 3'd2, 4'hF, 32'h11223344, 1'b1);
    slv_bresp = 2'd0;

    // store beats a same-cycle load
    exp_aw.push_back({32'h30000040, 3'd0});
    exp_w.push_back({4'h1, 32'h00000077});
    exp_rsp.push_back(mk_rsp(3'b100, 32'h0, 1'b0));
    exp_ar.push_back({32'h20000040, 3'd2});
    exp_rsp.push_back(mk_rsp(3'b010, 32'h20000040 ^ RD_KEY, 1'b0));
    fork
      do_store(32'h30000040, 32'h00000077, 8'h01);
      do_load(32'h20000040, 8'h0f);
    join

    // reset while waiting for rvalid
    repeat (2) @(posedge clk);
    #1;
    slv_hold = 1'b1;
    exp_ar.push_back({32'h80000200, 3'd2});
    ifu_araddr  = 32'h80000200;
    ifu_arvalid = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bus_rready) seen = 1;
    end
    if (!seen) chk("rready_timeout", 64'h0, 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_valids", {55'b0, bus_arvalid, bus_rready, bus_awvalid, bus_wvalid, bus_bready,
                         ifu_rvalid_o, lsu_rvalid_o, lsu_wready_o, bus_err_o}, 64'h0);
    chk("abort_addr", {bus_araddr, bus_awaddr}, 64'h0);
    ifu_arvalid = 1'b0;
    slv_hold    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    exp_ar.push_back({32'h80000008, 3'd2});
    exp_rsp.push_back(mk_rsp(3'b001, 32'h80000008 ^ RD_KEY, 1'b0));
    do_fetch(32'h80000008, lat);
    chk("post_reset_latency", 64'(lat), 64'd3);

    // drain and confirm nothing is left outstanding
    repeat (5) @(posedge clk);
    #1;
    chk("left_ar", 64'(exp_ar.size()), 64'h0);
    chk("left_aw_w", 64'(exp_aw.size() + exp_w.size()), 64'h0);
    chk("left_rsp", 64'(exp_rsp.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
